// File: rtl/axil_reg_bridge_pkg.sv
// Shared types and response codes for the AXI4-Lite register bridge.
package axil_reg_bridge_pkg;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_addr_decode.sv
// Byte address to register index, in-range flag and one-hot select; ADDR[1:0] are ignored.
module axil_addr_decode
    import axil_reg_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-3:0] idx,
    output logic                  in_range,
    output logic [NUM_REGS-1:0]   onehot
);

    always_comb begin
        idx      = addr[ADDR_WIDTH-1:2];
        in_range = (32'(idx) < 32'(NUM_REGS));
        onehot   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = (32'(idx) == 32'(i));
        end
    end

endmodule

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite responder for a bank of NUM_REGS registers: one write and one read outstanding,
// writes issue a one-cycle WEN pulse with byte-merged data.
module axil_reg_bridge
    import axil_reg_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic                           CLK,
    input  logic                           RSTN,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS-1:0]            REG_WEN,
    output logic [DATA_WIDTH-1:0]          REG_WDATA,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] REG_VALUES
);

    localparam int STRB_W = DATA_WIDTH / 8;

    // Handshake rule on every channel: a transfer happens at a posedge where VALID and READY
    // are both high; VALID/payload from the source must hold until that edge.

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic                    active;
    logic                    aw_held, w_held;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;

    logic [ADDR_WIDTH-3:0]   wr_idx, rd_idx;
    logic                    wr_in_range, rd_in_range;
    logic [NUM_REGS-1:0]     wr_onehot, rd_onehot;
    logic [DATA_WIDTH-1:0]   wr_cur, rd_cur, merged;
    logic                    unused_idx;

    assign unused_idx = ^{wr_idx, rd_idx};

    axil_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_wr_decode (
        .addr     (awaddr_q),
        .idx      (wr_idx),
        .in_range (wr_in_range),
        .onehot   (wr_onehot)
    );

    axil_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_rd_decode (
        .addr     (ARADDR),
        .idx      (rd_idx),
        .in_range (rd_in_range),
        .onehot   (rd_onehot)
    );

    // Out-of-range selects have an all-zero one-hot, so they read as 0.
    always_comb begin
        wr_cur = '0;
        rd_cur = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_onehot[i]) wr_cur = wr_cur | REG_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
            if (rd_onehot[i]) rd_cur = rd_cur | REG_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        merged = wr_cur;
        for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) merged[b*8 +: 8] = wdata_q[b*8 +: 8];
        end
    end

    // Write FSM
    always_comb begin
        wr_next   = wr_state;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        BRESP     = RESP_OKAY;
        REG_WEN   = '0;
        REG_WDATA = '0;
        case (wr_state)
            W_IDLE: begin
                AWREADY = active && !aw_held;
                WREADY  = active && !w_held;
                if (aw_held && w_held) wr_next = W_EXEC;
            end
            W_EXEC: begin
                REG_WEN   = wr_in_range ? wr_onehot : '0;
                REG_WDATA = merged;
                wr_next   = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                BRESP  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                if (BREADY) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // active keeps every READY low while RSTN is low and for the first cycle after release.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            active   <= 1'b0;
            wr_state <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            active   <= 1'b1;
            wr_state <= wr_next;
            if (AWVALID && AWREADY) begin
                aw_held  <= 1'b1;
                awaddr_q <= AWADDR;
            end
            if (WVALID && WREADY) begin
                w_held  <= 1'b1;
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
            if (wr_state == W_IDLE && wr_next == W_EXEC) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Read FSM
    always_comb begin
        rd_next = rd_state;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                ARREADY = active;
                if (ARVALID && active) rd_next = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            rd_state <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (ARVALID && ARREADY) begin
                rdata_q <= rd_cur;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign RDATA = rdata_q;
    assign RRESP = rresp_q;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Directed bench for axil_reg_bridge with a simple 8-entry register file behind it.
module tb_axil_reg_bridge;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [7:0]  AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [7:0]  ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [7:0]  REG_WEN;
    logic [31:0] REG_WDATA;
    logic [255:0] REG_VALUES;

    int vectors = 0;
    int miscompares = 0;

    axil_reg_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(8)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .REG_WEN(REG_WEN), .REG_WDATA(REG_WDATA), .REG_VALUES(REG_VALUES)
    );

    // clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // register file stub
    logic [31:0] regs [8] = '{32'hA5A50000, 32'hA5A50001, 32'h11223344, 32'h33333333,
                              32'hA5A50004, 32'hA5A50005, 32'hA5A50006, 32'hA5A50007};

    always @(posedge CLK) begin
        for (int i = 0; i < 8; i++) if (REG_WEN[i]) regs[i] <= REG_WDATA;
    end

    always_comb begin
        REG_VALUES = '0;
        for (int i = 0; i < 8; i++) REG_VALUES[i*32 +: 32] = regs[i];
    end

    // WEN pulse monitor
    int          wen_pulses = 0;
    logic [7:0]  last_wen = '0;
    logic [31:0] last_wdata = '0;

    always @(negedge CLK) begin
        if (REG_WEN != 8'h00) begin
            wen_pulses <= wen_pulses + 1;
            last_wen   <= REG_WEN;
            last_wdata <= REG_WDATA;
        end
    end

    // driver tasks
    task automatic send_aw_w(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        AWADDR = addr; AWVALID = 1'b1; WDATA = data; WSTRB = strb; WVALID = 1'b1;
        while (!(AWREADY && WREADY) && n < 50) begin @(negedge CLK); n++; end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL aw_w_accept: got no ready within 50 cycles, expected AWREADY=WREADY=1");
        end
        @(posedge CLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n = 0;
        while (!BVALID && n < 50) begin @(negedge CLK); n++; end
        if (!BVALID) begin
            vectors++; miscompares++;
            $display("FAIL bvalid_wait: got BVALID=0 after 50 cycles, expected 1");
        end
        resp = BRESP;
        BREADY = 1'b1;
        @(posedge CLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp);
        @(negedge CLK);
        send_aw_w(addr, data, strb);
        wait_b(resp);
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        @(negedge CLK);
        ARADDR = addr; ARVALID = 1'b1;
        while (!ARREADY && n < 50) begin @(negedge CLK); n++; end
        @(posedge CLK); #1;
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 50) begin @(negedge CLK); n++; end
        if (!RVALID) begin
            vectors++; miscompares++;
            $display("FAIL rvalid_wait: got RVALID=0 after 50 cycles, expected 1");
        end
        data = RDATA; resp = RRESP;
        RREADY = 1'b1;
        @(posedge CLK); #1;
        RREADY = 1'b0;
    endtask

    // tests
    task automatic test_reset();
        RSTN = 1'b0;
        repeat (3) @(negedge CLK);
        vectors++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ready_valid: got %b, expected 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        vectors++;
        if ({REG_WEN, REG_WDATA, RDATA, BRESP, RRESP} !== 76'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h, expected 0", {REG_WEN, REG_WDATA, RDATA, BRESP, RRESP});
        end
        RSTN = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b, expected 111", {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_same_cycle();
        logic [1:0] resp; logic [31:0] data; int base;
        base = wen_pulses;
        do_write(8'h04, 32'hDEADBEEF, 4'hF, resp);
        vectors++;
        if (resp !== 2'b00) begin miscompares++; $display("FAIL t1_bresp: got %b, expected 00", resp); end
        vectors++;
        if (wen_pulses - base !== 1) begin miscompares++; $display("FAIL t1_wen_count: got %0d, expected 1", wen_pulses - base); end
        vectors++;
        if (last_wen !== 8'h02) begin miscompares++; $display("FAIL t1_wen: got %h, expected 02", last_wen); end
        vectors++;
        if (last_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL t1_wdata: got %h, expected deadbeef", last_wdata); end
        do_read(8'h04, data, resp);
        vectors++;
        if ({resp, data} !== {2'b00, 32'hDEADBEEF}) begin
            miscompares++; $display("FAIL t1_readback: got %b/%h, expected 00/deadbeef", resp, data);
        end
        do_read(8'h07, data, resp);
        vectors++;
        if ({resp, data} !== {2'b00, 32'hDEADBEEF}) begin
            miscompares++; $display("FAIL t1_unaligned_read: got %b/%h, expected 00/deadbeef", resp, data);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; int base;
        base = wen_pulses;
        @(negedge CLK);
        WDATA = 32'hAABBCCDD; WSTRB = 4'h5; WVALID = 1'b1;
        @(posedge CLK); #1;
        WVALID = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({WREADY, AWREADY} !== 2'b01) begin
            miscompares++; $display("FAIL t2_ready_after_w: got %b, expected 01", {WREADY, AWREADY});
        end
        repeat (2) @(negedge CLK);
        vectors++;
        if (wen_pulses - base !== 0) begin miscompares++; $display("FAIL t2_early_wen: got %0d, expected 0", wen_pulses - base); end
        AWADDR = 8'h08; AWVALID = 1'b1;
        @(posedge CLK); #1;
        AWVALID = 1'b0;
        wait_b(resp);
        vectors++;
        if (resp !== 2'b00) begin miscompares++; $display("FAIL t2_bresp: got %b, expected 00", resp); end
        vectors++;
        if (wen_pulses - base !== 1) begin miscompares++; $display("FAIL t2_wen_count: got %0d, expected 1", wen_pulses - base); end
        vectors++;
        if ({last_wen, last_wdata} !== {8'h04, 32'h11BB33DD}) begin
            miscompares++; $display("FAIL t2_merge: got %h/%h, expected 04/11bb33dd", last_wen, last_wdata);
        end
        base = wen_pulses;
        do_write(8'h18, 32'hFFFFFFFF, 4'h0, resp);
        vectors++;
        if ({wen_pulses - base, last_wen, last_wdata} !== {32'd1, 8'h40, 32'hA5A50006}) begin
            miscompares++; $display("FAIL t2_zero_strobe: got %0d/%h/%h, expected 1/40/a5a50006", wen_pulses - base, last_wen, last_wdata);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] data; int base;
        base = wen_pulses;
        do_write(8'h40, 32'h12345678, 4'hF, resp);
        vectors++;
        if ({resp, wen_pulses - base} !== {2'b10, 32'd0}) begin
            miscompares++; $display("FAIL t3_write_slverr: got %b/%0d, expected 10/0", resp, wen_pulses - base);
        end
        do_write(8'h20, 32'h12345678, 4'hF, resp);
        vectors++;
        if ({resp, wen_pulses - base} !== {2'b10, 32'd0}) begin
            miscompares++; $display("FAIL t3_write_first_oob: got %b/%0d, expected 10/0", resp, wen_pulses - base);
        end
        do_read(8'h40, data, resp);
        vectors++;
        if ({resp, data} !== {2'b10, 32'h0}) begin
            miscompares++; $display("FAIL t3_read_slverr: got %b/%h, expected 10/00000000", resp, data);
        end
        do_read(8'h1C, data, resp);
        vectors++;
        if ({resp, data} !== {2'b00, 32'hA5A50007}) begin
            miscompares++; $display("FAIL t3_read_last_reg: got %b/%h, expected 00/a5a50007", resp, data);
        end
    endtask

    task automatic test_back_pressure();
        int n = 0;
        @(negedge CLK);
        send_aw_w(8'h14, 32'hCAFEF00D, 4'hF);
        while (!BVALID && n < 50) begin @(negedge CLK); n++; end
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            vectors++;
            if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin
                miscompares++; $display("FAIL t4_b_hold cycle %0d: got %b, expected 10000", c, {BVALID, BRESP, AWREADY, WREADY});
            end
        end
        BREADY = 1'b1;
        @(posedge CLK); #1;
        BREADY = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
            miscompares++; $display("FAIL t4_b_release: got %b, expected 011", {BVALID, AWREADY, WREADY});
        end
        ARADDR = 8'h14; ARVALID = 1'b1;
        @(posedge CLK); #1;
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 50) begin @(negedge CLK); n++; end
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            vectors++;
            if ({RVALID, ARREADY, RRESP, RDATA} !== {1'b1, 1'b0, 2'b00, 32'hCAFEF00D}) begin
                miscompares++; $display("FAIL t4_r_hold cycle %0d: got %b/%b/%b/%h, expected 1/0/00/cafef00d", c, RVALID, ARREADY, RRESP, RDATA);
            end
        end
        RREADY = 1'b1;
        @(posedge CLK); #1;
        RREADY = 1'b0;
    endtask

    task automatic test_read_during_wen();
        logic [1:0] resp; logic [31:0] data; int base; int n = 0;
        base = wen_pulses;
        @(negedge CLK);
        send_aw_w(8'h0C, 32'h00000005, 4'hF);
        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (REG_WEN !== 8'h08) begin miscompares++; $display("FAIL t5_wen_timing: got %h, expected 08", REG_WEN); end
        ARADDR = 8'h0C; ARVALID = 1'b1;
        @(posedge CLK); #1;
        ARVALID = 1'b0;
        while (!RVALID && n < 50) begin @(negedge CLK); n++; end
        vectors++;
        if ({RVALID, RRESP, RDATA} !== {1'b1, 2'b00, 32'h33333333}) begin
            miscompares++; $display("FAIL t5_old_value: got %b/%b/%h, expected 1/00/33333333", RVALID, RRESP, RDATA);
        end
        RREADY = 1'b1;
        @(posedge CLK); #1;
        RREADY = 1'b0;
        wait_b(resp);
        do_read(8'h0C, data, resp);
        vectors++;
        if ({resp, data, wen_pulses - base} !== {2'b00, 32'h00000005, 32'd1}) begin
            miscompares++; $display("FAIL t5_new_value: got %b/%h/%0d, expected 00/00000005/1", resp, data, wen_pulses - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = wen_pulses;
        @(negedge CLK);
        send_aw_w(8'h10, 32'h44444444, 4'hF);
        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (REG_WEN !== 8'h10) begin miscompares++; $display("FAIL t6_in_exec: got %h, expected 10", REG_WEN); end
        RSTN = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, REG_WEN, REG_WDATA, BRESP} !== 47'h0) begin
            miscompares++; $display("FAIL t6_wr_reset_outputs: got %h, expected 0", {AWREADY, WREADY, ARREADY, BVALID, RVALID, REG_WEN, REG_WDATA, BRESP});
        end
        RSTN = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({AWREADY, WREADY, ARREADY, BVALID} !== 4'b1110) begin
            miscompares++; $display("FAIL t6_wr_release: got %b, expected 1110", {AWREADY, WREADY, ARREADY, BVALID});
        end
        repeat (4) @(negedge CLK);
        vectors++;
        if ({BVALID, wen_pulses - base} !== {1'b0, 32'd1}) begin
            miscompares++; $display("FAIL t6_no_b_after_reset: got %b/%0d, expected 0/1", BVALID, wen_pulses - base);
        end
        ARADDR = 8'h04; ARVALID = 1'b1;
        @(posedge CLK); #1;
        ARVALID = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({RVALID, RDATA} !== {1'b1, 32'hDEADBEEF}) begin
            miscompares++; $display("FAIL t6_in_rdata: got %b/%h, expected 1/deadbeef", RVALID, RDATA);
        end
        RSTN = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({RVALID, ARREADY, RRESP, RDATA} !== 36'h0) begin
            miscompares++; $display("FAIL t6_rd_reset_outputs: got %b/%b/%b/%h, expected 0/0/00/00000000", RVALID, ARREADY, RRESP, RDATA);
        end
        RSTN = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({ARREADY, RVALID} !== 2'b10) begin
            miscompares++; $display("FAIL t6_rd_release: got %b, expected 10", {ARREADY, RVALID});
        end
        repeat (3) @(negedge CLK);
        vectors++;
        if (RVALID !== 1'b0) begin miscompares++; $display("FAIL t6_no_r_after_reset: got %b, expected 0", RVALID); end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_out_of_range();
        test_back_pressure();
        test_read_during_wen();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
